data_mem_mmio: RTL
==================

Name: data_mem_mmio

Overview:
- Next-generation data memory for the single-cycle core: parametrised word-addressed RAM with per-byte write enables, plus a 16-byte memory-mapped UART register window.
- The window replaces fixed "magic" RAM locations with real registers: DATA, CONFIG, BAUD_DIV and a read-only STATUS.
- Adds TX valid/ready and RX capture handshakes, sticky overrun flags and address-error detection.
- Sits between the core's load/store path and the UART TX/RX engines.

Parameters:
- DEPTH, 2048, RAM size in 32-bit words.
- DATA_W, 32, data bus width; must be a multiple of 8.
- ADDR_W, 32, byte-address width.
- MMIO_BASE, 32'h0000_1000, byte base of the register window; 16-byte aligned.
- RESET_BAUD, 16'd868, BAUD_DIV reset value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  store strobe.
- rd_en  in  1  load strobe.
- address  in  ADDR_W  byte address; bits [1:0] ignored (word access only).
- wdata  in  DATA_W  store data.
- byte_en  in  DATA_W/8  per-byte write enable.
- rdata  out  DATA_W  load data (combinational).
- addr_err  out  1  access falls outside both RAM and window (combinational).
- tx_data  out  8  byte offered to the UART transmitter.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts at a rising edge when tx_valid=1.
- rx_data  in  8  received byte.
- rx_valid  in  1  single-cycle strobe; capture rx_data.
- config_r  out  DATA_W  CONFIG register contents.
- baud_div  out  16  BAUD_DIV register contents.

Behaviour:
- Decode
  - Word index w = address[ADDR_W-1:2].
  - RAM hit when w < DEPTH.
  - Window hit when address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]. Offsets: 0x0 DATA, 0x4 CONFIG, 0x8 BAUD_DIV, 0xC STATUS.
  - The window takes priority if the two regions overlap.
  - addr_err = (rd_en|wr_en) & no hit.
- RAM
  - Write at the rising edge when wr_en and a RAM hit; only bytes with byte_en[i]=1 are written.
  - RAM contents are not reset.
  - rdata = rd_en ? selected word : 0. Reads are combinational, zero latency.
  - A miss (addr_err=1) reads 0 and drops writes; no state changes.
- Reset values: config_r=0, baud_div=RESET_BAUD, tx_valid=0, tx_data=0, rx_full=0, both overrun flags=0, rdata=0 while rd_en=0, addr_err=0 while idle. Reset mid-transfer drops the pending TX byte and RX byte.
- CONFIG
  - Byte-enabled read/write.
  - config_r[0] = tx_en. While tx_en=0, DATA writes are dropped without setting overrun.
- BAUD_DIV
  - Bits [15:0] are writable when byte_en[1:0]; upper bits read 0.
  - A write whose resulting value is 0 is ignored; the old value is kept.
- TX
  - A write to DATA with byte_en[0]=1, tx_en=1 and tx_valid=0 loads tx_data <= wdata[7:0]; tx_valid=1 from the next cycle.
  - tx_valid clears at the edge where tx_ready=1.
  - A DATA write while tx_valid=1 and tx_ready=0 is dropped and sets tx_overrun.
  - A DATA write in the same cycle as tx_valid & tx_ready is accepted: new byte loaded, tx_valid stays 1, no overrun.
- RX
  - rx_valid loads rx_buf and sets rx_full.
  - A read of DATA returns {zeros, rx_buf}; rx_full clears at that edge.
  - rx_valid while rx_full=1 with no DATA read that cycle: overwrite rx_buf and set rx_overrun.
  - rx_valid in the same cycle as a DATA read: new byte loaded, rx_full stays 1, no overrun.
- STATUS (read)
  - bit0 tx_valid, bit1 rx_full, bit2 tx_overrun, bit3 rx_overrun; other bits 0.
  - Writing 1 to bit2/bit3 clears that flag (write-1-to-clear, requires byte_en[0]). Other bits are read-only.
  - If set and clear happen in the same cycle, set wins.
- Reads never change state, except that a DATA read clears rx_full.

Test Plan:
- Reset, then read CONFIG/BAUD_DIV/STATUS -> 0, 868, 0. Write BAUD_DIV=0 -> still reads 868. Write 434 -> baud_div=434.
- Write RAM word 5 = 0xAABBCCDD, then write 0x11223344 with byte_en=4'b0101 -> read 0xAA22CC44. Read address 0x0000_4000 (word 4096) -> rdata=0, addr_err=1, RAM unchanged.
- CONFIG=1, write DATA=0x41 -> tx_valid=1, tx_data=0x41 next cycle. Hold tx_ready=0, write DATA=0x42 -> dropped, STATUS=0x5. tx_ready=1 -> tx_valid=0. Write STATUS=0x4 -> STATUS=0.
- tx_valid pending; DATA write of 0x55 in the same cycle as tx_ready=1 -> tx_data=0x55, tx_valid stays 1, no overrun. With CONFIG=0, DATA write -> tx_valid stays 0.
- rx_valid with 0x37 -> STATUS bit1=1; read DATA -> 0x37, rx_full=0 next cycle. Two rx_valid pulses without a read -> second byte kept, rx_overrun=1. rx_valid during a DATA read -> rx_full stays 1, no overrun.
- Assert reset with tx_valid=1 and rx_full=1 -> all outputs and flags return to reset values next edge; RAM contents preserved.

Source files
------------

// File: rtl/data_mem_mmio.sv
// Data memory for the single-cycle core: word-addressed RAM with byte enables
// plus a 16-byte UART register window (DATA, CONFIG, BAUD_DIV, STATUS).
module data_mem_mmio #(
  parameter int unsigned       DEPTH      = 2048,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 32'h0000_1000,
  parameter logic [15:0]       RESET_BAUD = 16'd868
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   rdata,
  output logic                addr_err,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [DATA_W-1:0]   config_r,
  output logic [15:0]         baud_div
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IdxW = $clog2(DEPTH);

  localparam logic [1:0] OffData   = 2'd0;
  localparam logic [1:0] OffConfig = 2'd1;
  localparam logic [1:0] OffBaud   = 2'd2;
  localparam logic [1:0] OffStatus = 2'd3;

  // Address decode
  logic [ADDR_W-3:0] word_idx;
  logic              win_hit;
  logic              ram_in_range;
  logic              ram_hit;
  logic [IdxW-1:0]   ram_idx;
  logic [1:0]        reg_off;
  logic              unused_addr_lsb;

  assign word_idx        = address[ADDR_W-1:2];
  assign win_hit         = (address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
  assign ram_in_range    = (word_idx < (ADDR_W-2)'(DEPTH));
  // Window shadows any RAM words it overlaps.
  assign ram_hit         = ram_in_range & ~win_hit;
  assign ram_idx         = address[IdxW+1:2];
  assign reg_off         = address[3:2];
  assign unused_addr_lsb = ^address[1:0];
  assign addr_err        = (rd_en | wr_en) & ~(win_hit | ram_in_range);

  // Register-window access strobes
  logic data_wr, data_rd, cfg_wr, baud_wr, stat_wr;

  assign data_wr = wr_en & win_hit & (reg_off == OffData) & byte_en[0];
  assign data_rd = rd_en & win_hit & (reg_off == OffData);
  assign cfg_wr  = wr_en & win_hit & (reg_off == OffConfig);
  assign baud_wr = wr_en & win_hit & (reg_off == OffBaud) & (|byte_en[1:0]);
  assign stat_wr = wr_en & win_hit & (reg_off == OffStatus) & byte_en[0];

  // RAM storage; contents deliberately survive reset
  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-enabled RAM write on a RAM hit only
  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // UART register state
  logic [DATA_W-1:0] config_q, config_d;
  logic [15:0]       baud_q, baud_d, baud_new;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        rx_buf_q, rx_buf_d;
  logic              rx_full_q, rx_full_d;
  logic              tx_ovr_q, tx_ovr_d;
  logic              rx_ovr_q, rx_ovr_d;

  // Next-state for the register window, TX handshake and RX capture
  always_comb begin
    config_d   = config_q;
    baud_d     = baud_q;
    baud_new   = baud_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rx_buf_d   = rx_buf_q;
    rx_full_d  = rx_full_q;
    tx_ovr_d   = tx_ovr_q;
    rx_ovr_d   = rx_ovr_q;

    if (cfg_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          config_d[8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end

    if (baud_wr) begin
      if (byte_en[0]) baud_new[7:0]  = wdata[7:0];
      if (byte_en[1]) baud_new[15:8] = wdata[15:8];
      // A zero divisor would stall the UART; keep the old value instead.
      if (baud_new != 16'd0) baud_d = baud_new;
    end

    // Clears are applied before sets so a same-cycle set wins.
    if (stat_wr) begin
      if (wdata[2]) tx_ovr_d = 1'b0;
      if (wdata[3]) rx_ovr_d = 1'b0;
    end

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
    if (data_wr && config_q[0]) begin
      // Slot is free if empty or being drained at this very edge.
      if (!tx_valid_q || tx_ready) begin
        tx_data_d  = wdata[7:0];
        tx_valid_d = 1'b1;
      end else begin
        tx_ovr_d = 1'b1;
      end
    end

    if (data_rd) rx_full_d = 1'b0;
    if (rx_valid) begin
      rx_buf_d  = rx_data;
      rx_full_d = 1'b1;
      if (rx_full_q && !data_rd) rx_ovr_d = 1'b1;
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      config_q   <= '0;
      baud_q     <= RESET_BAUD;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_buf_q   <= 8'h00;
      rx_full_q  <= 1'b0;
      tx_ovr_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      config_q   <= config_d;
      baud_q     <= baud_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_buf_q   <= rx_buf_d;
      rx_full_q  <= rx_full_d;
      tx_ovr_q   <= tx_ovr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // Combinational load data; zero when idle or on a miss
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (win_hit) begin
        case (reg_off)
          OffData:   rdata = DATA_W'(rx_buf_q);
          OffConfig: rdata = config_q;
          OffBaud:   rdata = DATA_W'(baud_q);
          OffStatus: rdata = DATA_W'({rx_ovr_q, tx_ovr_q, rx_full_q, tx_valid_q});
          default:   rdata = '0;
        endcase
      end else if (ram_hit) begin
        rdata = mem[ram_idx];
      end
    end
  end

  assign config_r = config_q;
  assign baud_div = baud_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule
